// File: rtl/muldiv_unit_pkg.sv
// Shared function codes, FSM states and decode helpers for the iterative multiply/divide unit.
// No timing of its own; the latency and stall behaviour live in muldiv_unit.
package muldiv_unit_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

  function automatic logic is_div(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || is_div(f);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply (shift-add) and divide (restoring). Start at edge T gives Busy in T+1..T+33 and Done in T+34.
// There is no queueing: Start is ignored while Busy is high, so EX must stall and hold the request until Busy drops.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [5:0]         funct_q, funct_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   b_q, b_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, remv;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    funct_d = funct_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    b_d     = b_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    op_signed = (Funct == FN_MULT) || (Funct == FN_DIV);
    a_mag     = (op_signed && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
    b_mag     = (op_signed && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;

    // acc holds {partial product, multiplier} for multiply; low half is dividend/quotient for divide
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};

    quo  = acc_q[WIDTH-1:0];
    remv = rem_q;
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (Start && is_muldiv(Funct)) begin
          funct_d = Funct;
          sa_d    = op_signed && Rdata1[WIDTH-1];
          sb_d    = op_signed && Rdata2[WIDTH-1];
          b_d     = is_div(Funct) ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, is_div(Funct) ? a_mag : b_mag};
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = ST_ITER;
        end else if (Start && Funct == FN_MTHI) begin
          hi_d = Rdata1;
        end else if (Start && Funct == FN_MTLO) begin
          lo_d = Rdata1;
        end
      end
      ST_ITER: begin
        if (is_div(funct_q)) begin
          acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
          rem_d            = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        if (is_div(funct_q)) begin
          // a zero divisor naturally yields remainder = dividend, so only LO needs forcing
          lo_d = (b_q == '0) ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
          hi_d = sa_q ? -remv : remv;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      funct_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      b_q     <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      funct_q <= funct_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of hand-computed results plus timing and corner sequences.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [5:0]  Funct;
  logic [31:0] Rdata1, Rdata2;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct),
    .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int busy_n;
  int done_at;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge in an IDLE/Done cycle; returns at the negedge of the Done cycle (or after the bound).
  task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit hold);
    Funct = f; Rdata1 = a; Rdata2 = b; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = hold;
    if (hold) begin
      Funct = FN_MULTU; Rdata1 = 32'h0BAD_F00D; Rdata2 = 32'h0000_0003;
    end
    busy_n  = 0;
    done_at = 0;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      if (Busy) busy_n++;
      if (Done) done_at = k;
      else @(negedge CLK);
    end
    Start = 1'b0;
  endtask

  task automatic chk_timing(input string name);
    chk({name, "_busy_cycles"}, busy_n, 33);
    chk({name, "_done_cycle"}, done_at, 34);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_seen;
    vecs[0]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[1]  = '{FN_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"};
    vecs[2]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq"};
    vecs[3]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"};
    vecs[4]  = '{FN_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, "divu_7_2"};
    vecs[5]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
    vecs[6]  = '{FN_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu_by0"};
    vecs[7]  = '{FN_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift"};
    vecs[8]  = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2"};
    vecs[9]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0"};
    vecs[10] = '{FN_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7xneg3"};
    vecs[11] = '{FN_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_neg1sq"};

    RST = 1'b1; Start = 1'b0; Funct = '0; Rdata1 = '0; Rdata2 = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // MTHI / MTLO: immediate write, no Busy, no Done
    Start = 1'b1; Funct = FN_MTHI; Rdata1 = 32'h000000A5;
    @(negedge CLK);
    Start = 1'b0;
    chk("mthi_hi", HI, 32'h000000A5);
    chk("mthi_busy", {31'b0, Busy}, 32'd0);
    chk("mthi_lo_untouched", LO, 32'd0);
    @(negedge CLK);
    chk("mthi_no_done", {31'b0, Done}, 32'd0);
    Start = 1'b1; Funct = FN_MTLO; Rdata1 = 32'h0000005A;
    @(negedge CLK);
    Start = 1'b0;
    chk("mtlo_lo", LO, 32'h0000005A);
    chk("mtlo_hi_kept", HI, 32'h000000A5);

    // MFHI is not an operation for this block
    Start = 1'b1; Funct = FN_MFHI; Rdata1 = 32'h11111111;
    @(negedge CLK);
    Start = 1'b0;
    chk("mfhi_ignored_busy", {31'b0, Busy}, 32'd0);
    chk("mfhi_ignored_hi", HI, 32'h000000A5);

    for (int i = 0; i < 12; i++) begin
      run(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0);
      chk_timing(vecs[i].name);
      chk({vecs[i].name, "_hi"}, HI, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, LO, vecs[i].lo);
      @(negedge CLK);
      chk({vecs[i].name, "_done_pulse"}, {31'b0, Done}, 32'd0);
    end

    // Start held through Busy with different operands: only the first request counts
    run(FN_DIVU, 32'h00000007, 32'h00000002, 1'b1);
    chk_timing("hold");
    chk("hold_hi", HI, 32'h00000001);
    chk("hold_lo", LO, 32'h00000003);
    @(negedge CLK);
    chk("hold_idle_after", {31'b0, Busy}, 32'd0);

    // Back-to-back: second Start issued in the Done cycle of the first
    run(FN_MULTU, 32'h00000003, 32'h00000005, 1'b0);
    chk_timing("b2b_first");
    chk("b2b_first_lo", LO, 32'h0000000F);
    run(FN_DIVU, 32'h00000064, 32'h00000007, 1'b0);
    chk_timing("b2b_second");
    chk("b2b_second_hi", HI, 32'h00000002);
    chk("b2b_second_lo", LO, 32'h0000000E);
    @(negedge CLK);

    // Reset in cycle T+10 of a DIV aborts it
    Start = 1'b1; Funct = FN_DIV; Rdata1 = 32'hFFFFFFF9; Rdata2 = 32'h00000002;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    chk("abort_busy_before", {31'b0, Busy}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_done", {31'b0, Done}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (Done || Busy) done_seen = 1'b1;
    end
    chk("abort_no_late_done", {31'b0, done_seen}, 32'd0);
    chk("abort_hi_stays", HI, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
